// File: rtl/sar_ctrl_if.sv
// sar_ctrl_if: request/comparator/DAC signal bundle for the SAR controller.
// Revision 1.0 - initial release
`default_nettype none

interface sar_ctrl_if #(
   parameter int N_BIT = 8
);
   logic             start;
   logic             comp_dout;
   logic             comp_doutb;
   logic             comp_clk;
   logic             comp_pwdn;
   logic             sample;
   logic [N_BIT-1:0] dac_code;
   logic [N_BIT-1:0] dout;
   logic             valid;
   logic             busy;
   logic             meta_err;

   modport master (
      output start, comp_dout, comp_doutb,
      input  comp_clk, comp_pwdn, sample, dac_code, dout, valid, busy, meta_err
   );

   modport slave (
      input  start, comp_dout, comp_doutb,
      output comp_clk, comp_pwdn, sample, dac_code, dout, valid, busy, meta_err
   );
endinterface

`default_nettype wire

// File: rtl/sar_ctrl.sv
// sar_ctrl: SAR ADC sequencer (sample, then MSB-first strobe/decide per bit).
// Optional macro SAR_CTRL_METADET_EN enables invalid-decision detection. Revision 1.0
`default_nettype none

module sar_ctrl #(
   parameter int N_BIT      = 8,
   parameter int SAMPLE_CYC = 2,
   parameter int COMP_WAIT  = 1,
   parameter bit PWDN_IDLE  = 1'b1
) (
   input  wire logic clk,
   input  wire logic rstb,
   sar_ctrl_if.slave bus
);

   localparam int c_IDX_W = $clog2(N_BIT);
   localparam int c_CNT_W = 16;
   localparam logic [N_BIT-1:0]   c_CODE_INIT   = {1'b1, {(N_BIT-1){1'b0}}};
   localparam logic [c_IDX_W-1:0] c_IDX_MSB     = c_IDX_W'(N_BIT-1);
   localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE_CYC-1);
   localparam logic [c_CNT_W-1:0] c_COMP_LAST   = c_CNT_W'(COMP_WAIT-1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SAMPLE = 3'd1,
      S_COMP   = 3'd2,
      S_DECIDE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t               r_state, w_state;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt;
   logic [c_IDX_W-1:0]   r_idx, w_idx;
   logic [N_BIT-1:0]     r_code, w_code;
   logic [N_BIT-1:0]     r_dout, w_dout;
   logic                 r_valid, w_valid;
   logic                 r_comp_clk, w_comp_clk;
   logic                 r_pwdn, w_pwdn;
   logic                 r_sample, w_sample;
   logic                 r_busy, w_busy;
   logic                 r_meta_err, w_meta_err;
   logic                 w_dec;
   logic                 w_meta;

`ifdef SAR_CTRL_METADET_EN
   // Equal complementary outputs mean the latch never resolved; force the bit low.
   assign w_meta = (bus.comp_dout == bus.comp_doutb);
   assign w_dec  = bus.comp_dout & ~w_meta;
`else
   logic w_unused_doutb;
   assign w_unused_doutb = bus.comp_doutb;
   assign w_meta         = 1'b0;
   assign w_dec          = bus.comp_dout;
`endif

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_code     <= '0;
         r_dout     <= '0;
         r_valid    <= 1'b0;
         r_comp_clk <= 1'b0;
         r_pwdn     <= PWDN_IDLE;
         r_sample   <= 1'b0;
         r_busy     <= 1'b0;
         r_meta_err <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_idx      <= w_idx;
         r_code     <= w_code;
         r_dout     <= w_dout;
         r_valid    <= w_valid;
         r_comp_clk <= w_comp_clk;
         r_pwdn     <= w_pwdn;
         r_sample   <= w_sample;
         r_busy     <= w_busy;
         r_meta_err <= w_meta_err;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_idx      = r_idx;
      w_code     = r_code;
      w_dout     = r_dout;
      w_valid    = 1'b0;
      w_comp_clk = r_comp_clk;
      w_pwdn     = r_pwdn;
      w_sample   = r_sample;
      w_busy     = r_busy;
      w_meta_err = r_meta_err;

      // Next-value outputs are computed here so every port leaves a flop.
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_state    = S_SAMPLE;
               w_cnt      = '0;
               w_idx      = c_IDX_MSB;
               w_code     = c_CODE_INIT;
               w_sample   = 1'b1;
               w_pwdn     = 1'b0;
               w_busy     = 1'b1;
               w_meta_err = 1'b0;
            end else begin
               w_state = S_IDLE;
               w_pwdn  = PWDN_IDLE;
            end
         end
         S_SAMPLE: begin
            if (r_cnt == c_SAMPLE_LAST) begin
               w_state    = S_COMP;
               w_cnt      = '0;
               w_sample   = 1'b0;
               w_comp_clk = 1'b1;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_COMP: begin
            if (r_cnt == c_COMP_LAST) begin
               w_state    = S_DECIDE;
               w_cnt      = '0;
               w_comp_clk = 1'b0;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_DECIDE: begin
            w_code[r_idx] = w_dec;
            if (w_meta) begin
               w_meta_err = 1'b1;
            end
            if (r_idx != '0) begin
               w_code[r_idx - 1'b1] = 1'b1;
               w_idx                = r_idx - 1'b1;
               w_state              = S_COMP;
               w_comp_clk           = 1'b1;
            end else begin
               w_state = S_DONE;
               w_dout  = w_code;
               w_valid = 1'b1;
               w_busy  = 1'b0;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign bus.comp_clk  = r_comp_clk;
   assign bus.comp_pwdn = r_pwdn;
   assign bus.sample    = r_sample;
   assign bus.dac_code  = r_code;
   assign bus.dout      = r_dout;
   assign bus.valid     = r_valid;
   assign bus.busy      = r_busy;
   assign bus.meta_err  = r_meta_err;

endmodule

`default_nettype wire

// File: tb/tb_sar_ctrl.sv
// tb_sar_ctrl: self-checking bench for sar_ctrl (8-bit default and 4-bit timing variant).
`default_nettype none

module tb_sar_ctrl;

`ifdef SAR_CTRL_METADET_EN
   localparam bit c_METADET = 1'b1;
`else
   localparam bit c_METADET = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   sar_ctrl_if #(.N_BIT(8)) if8 ();
   sar_ctrl_if #(.N_BIT(4)) if4 ();

   sar_ctrl #(.N_BIT(8), .SAMPLE_CYC(2), .COMP_WAIT(1), .PWDN_IDLE(1'b1)) u_dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (if8)
   );

   sar_ctrl #(.N_BIT(4), .SAMPLE_CYC(1), .COMP_WAIT(3), .PWDN_IDLE(1'b0)) u_dut4 (
      .clk  (clk),
      .rstb (rstb),
      .bus  (if4)
   );

   // Ideal comparators: decision is 1 when the DAC trial does not exceed the target.
   logic [7:0] tgt8;
   logic [3:0] tgt4;
   logic       meta_on;
   logic       w_meta_hit;
   assign w_meta_hit     = meta_on && if8.dac_code[6] && (if8.dac_code[5:0] == 6'd0);
   assign if8.comp_dout  = w_meta_hit | (if8.dac_code <= tgt8);
   assign if8.comp_doutb = w_meta_hit | ~(if8.dac_code <= tgt8);
   assign if4.comp_dout  = (if4.dac_code <= tgt4);
   assign if4.comp_doutb = ~(if4.dac_code <= tgt4);

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Binary search by arithmetic; meta_bit marks a bit whose decision is unresolved.
   function automatic int model_conv(input int nbit, input int t, input int meta_bit,
                                     output int trials[$]);
      int code;
      code   = 0;
      trials = {};
      for (int i = nbit - 1; i >= 0; i--) begin
         int trial;
         bit d;
         trial = code + (1 << i);
         trials.push_back(trial);
         d = (trial <= t) || (i == meta_bit);
         if (i == meta_bit && c_METADET) d = 1'b0;
         if (d) code = trial;
      end
      return code;
   endfunction

   task automatic run8(input logic [7:0] t, input bit meta6, output int lat,
                       output logic [7:0] got, output logic got_meta, output int trials[$]);
      logic prev_cc;
      tgt8     = t;
      meta_on  = meta6;
      trials   = {};
      lat      = -1;
      got      = '0;
      got_meta = 1'b0;
      prev_cc  = 1'b0;
      @(negedge clk);
      if8.start = 1'b1;
      @(posedge clk);
      #1 if8.start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (if8.comp_clk && !prev_cc) trials.push_back(int'(if8.dac_code));
         prev_cc = if8.comp_clk;
         if (if8.valid) begin
            lat      = k;
            got      = if8.dout;
            got_meta = if8.meta_err;
            break;
         end
      end
      @(posedge clk);
      #1;
      check("valid_one_cycle", {31'd0, if8.valid}, 32'd0);
      meta_on = 1'b0;
   endtask

   typedef struct {
      logic [7:0] tgt;
      bit         meta6;
      logic [7:0] exp_dout;
      logic       exp_meta;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int         lat;
      logic [7:0] got;
      logic       gmeta;
      int         trials[$];
      int         exp_tr[$];
      int         vtimes[$];
      int         nvalid;
      int         exp_code;

      if8.start = 1'b0;
      if4.start = 1'b0;
      tgt8      = 8'h00;
      tgt4      = 4'h0;
      meta_on   = 1'b0;

      #12;
      check("rst_comp_clk", {31'd0, if8.comp_clk}, 32'd0);
      check("rst_pwdn",     {31'd0, if8.comp_pwdn}, 32'd1);
      check("rst_pwdn4",    {31'd0, if4.comp_pwdn}, 32'd0);
      check("rst_sample",   {31'd0, if8.sample}, 32'd0);
      check("rst_dac",      {24'd0, if8.dac_code}, 32'd0);
      check("rst_dout",     {24'd0, if8.dout}, 32'd0);
      check("rst_valid",    {31'd0, if8.valid}, 32'd0);
      check("rst_busy",     {31'd0, if8.busy}, 32'd0);
      check("rst_meta",     {31'd0, if8.meta_err}, 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      repeat (2) @(posedge clk);

      vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
      vecs[3] = '{8'h80, 1'b0, 8'h80, 1'b0};
      vecs[4] = '{8'h7F, 1'b0, 8'h7F, 1'b0};
      vecs[5] = '{8'hFF, 1'b1, c_METADET ? 8'hBF : 8'hFF, c_METADET};
      vecs[6] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
      vecs[7] = '{8'h01, 1'b0, 8'h01, 1'b0};
      for (int v = 0; v < 8; v++) begin
         run8(vecs[v].tgt, vecs[v].meta6, lat, got, gmeta, trials);
         check("tbl_latency", lat, 32'd18);
         check("tbl_dout", {24'd0, got}, {24'd0, vecs[v].exp_dout});
         check("tbl_meta", {31'd0, gmeta}, {31'd0, vecs[v].exp_meta});
      end

      // Trial-code sequence for target A5.
      run8(8'hA5, 1'b0, lat, got, gmeta, trials);
      exp_code = model_conv(8, 'hA5, -1, exp_tr);
      check("seq_len", trials.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check("seq_code", (i < trials.size()) ? trials[i] : -1, exp_tr[i]);
      end
      check("seq_dout", {24'd0, got}, exp_code);

      // Random targets against the model, with an occasional unresolved bit 6.
      for (int r = 0; r < 24; r++) begin
         logic [7:0] t;
         bit         m;
         t = 8'($urandom_range(0, 255));
         m = ($urandom_range(0, 3) == 0);
         exp_code = model_conv(8, int'(t), m ? 6 : -1, exp_tr);
         run8(t, m, lat, got, gmeta, trials);
         check("rnd_latency", lat, 32'd18);
         check("rnd_dout", {24'd0, got}, exp_code);
         check("rnd_meta", {31'd0, gmeta}, {31'd0, m & c_METADET & ~t[6]} |
                                            {31'd0, m & c_METADET & t[6]});
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Back-to-back with start held high.
      tgt8 = 8'h5A;
      vtimes = {};
      @(negedge clk);
      if8.start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 70; k++) begin
         @(posedge clk);
         #1;
         if (if8.valid) begin
            vtimes.push_back(k);
            check("b2b_dout", {24'd0, if8.dout}, 32'h5A);
            if (vtimes.size() == 3) begin
               if8.start = 1'b0;
               break;
            end
         end
      end
      if8.start = 1'b0;
      check("b2b_count", vtimes.size(), 32'd3);
      if (vtimes.size() == 3) begin
         check("b2b_first", vtimes[0], 32'd18);
         check("b2b_gap1", vtimes[1] - vtimes[0], 32'd19);
         check("b2b_gap2", vtimes[2] - vtimes[1], 32'd19);
      end
      repeat (3) @(posedge clk);

      // Start pulsed while busy must not queue a second conversion.
      tgt8   = 8'hC3;
      nvalid = 0;
      @(negedge clk);
      if8.start = 1'b1;
      @(posedge clk);
      #1 if8.start = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) if8.start = 1'b1;
         if (k == 6) if8.start = 1'b0;
         if (if8.valid) nvalid++;
      end
      check("busy_ignore_valids", nvalid, 32'd1);
      check("busy_ignore_dout", {24'd0, if8.dout}, 32'hC3);

      // Asynchronous reset during the COMP phase of bit 5.
      tgt8 = 8'hFF;
      @(negedge clk);
      if8.start = 1'b1;
      @(posedge clk);
      #1 if8.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("pre_rst_comp_clk", {31'd0, if8.comp_clk}, 32'd1);
      check("pre_rst_dac", {24'd0, if8.dac_code}, 32'hE0);
      #2 rstb = 1'b0;
      #1;
      check("abort_comp_clk", {31'd0, if8.comp_clk}, 32'd0);
      check("abort_pwdn", {31'd0, if8.comp_pwdn}, 32'd1);
      check("abort_busy", {31'd0, if8.busy}, 32'd0);
      check("abort_dac", {24'd0, if8.dac_code}, 32'd0);
      check("abort_dout", {24'd0, if8.dout}, 32'd0);
      @(negedge clk);
      rstb   = 1'b1;
      nvalid = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (if8.valid || if8.busy) nvalid++;
      end
      check("abort_no_valid", nvalid, 32'd0);

      // 4-bit variant: SAMPLE_CYC=1, COMP_WAIT=3.
      for (int r = 0; r < 6; r++) begin
         int s_hi, cc_hi, run, max_run;
         tgt4 = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(0, 15));
         exp_code = model_conv(4, int'(tgt4), -1, exp_tr);
         s_hi = 0; cc_hi = 0; run = 0; max_run = 0; lat = -1;
         @(negedge clk);
         if4.start = 1'b1;
         @(posedge clk);
         #1 if4.start = 1'b0;
         if (if4.sample) s_hi++;
         for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (if4.sample) s_hi++;
            if (if4.comp_clk) begin
               cc_hi++;
               run++;
               if (run > max_run) max_run = run;
            end else begin
               run = 0;
            end
            if (if4.valid) begin
               lat = k;
               break;
            end
         end
         check("n4_latency", lat, 32'd17);
         check("n4_sample_cyc", s_hi, 32'd1);
         check("n4_comp_hi", cc_hi, 32'd12);
         check("n4_comp_run", max_run, 32'd3);
         check("n4_dout", {28'd0, if4.dout}, exp_code);
         repeat (2) @(posedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
